// File: rtl/full_adder_pkg.sv
// full_adder_pkg
// Shared definitions for the full_adder_r slice.
//   MAX_WIDTH : widest operand the adder is meant to be built for.
//   ref_add   : plain-arithmetic reference {cout, sum} for a MAX_WIDTH-wide add.
//               Narrower operands are passed in zero-extended.
//               The carry out then appears at bit WIDTH of the result.
package full_adder_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH:0] ref_add(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit
// Single-bit full adder cell. Purely combinational.
// Ports:
//   a, b : operand bits
//   cin  : carry in
//   cout : carry out (majority of a, b, cin)
//   sum  : a ^ b ^ cin
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder_r.sv
// full_adder_r
// Ripple-carry adder built from a chain of full_adder_bit cells.
// It has two result paths:
//   - combinational: sum and cout, zero latency, unaffected by reset.
//   - registered: sum_q, cout_q and ovf_q, captured when in_valid is high.
// Ports:
//   clk       : rising-edge clock for the output registers
//   rst_n     : asynchronous active-low reset; clears the registered outputs
//   a, b      : WIDTH-bit operands; unsigned, or two's complement for ovf
//   cin       : carry in
//   in_valid  : capture strobe
//   cout, sum : combinational result {cout, sum} = a + b + cin
//   sum_q     : registered sum
//   cout_q    : registered carry out
//   ovf_q     : registered signed overflow
//   out_valid : high for one cycle after each capture
module full_adder_r
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    // carry[i] is the carry into bit i.
    // carry[WIDTH] is the carry out of the top bit.
    logic [WIDTH:0] carry;
    logic           ovf;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        full_adder_bit u_bit (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (carry[gi]),
            .cout (carry[gi+1]),
            .sum  (sum[gi])
        );
    end

    assign cout = carry[WIDTH];

    // Signed overflow happens when the carries into and out of the sign bit differ.
    // For WIDTH=1, carry[0] is cin, so this reduces to cout ^ cin.
    assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

    // The result registers hold their value when in_valid is low.
    // out_valid only marks the cycle right after a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= sum;
                cout_q <= cout;
                ovf_q  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_r.sv
// tb_full_adder_r
// Self-checking bench for full_adder_r.
// It builds three instances, at WIDTH = 1, 8 and 64.
// Expected values come from a plain-arithmetic model:
//   - sum and cout from a widened integer add;
//   - ovf from the two's-complement sign rule, with the same operand signs
//     giving a result of a different sign.
module tb_full_adder_r;

    logic clk;
    logic rst_n;

    // WIDTH = 1 instance
    logic [0:0]  a1, b1, sum1, sum_q1;
    logic        cin1, iv1, cout1, cout_q1, ovf_q1, ov1;

    // WIDTH = 8 instance
    logic [7:0]  a8, b8, sum8, sum_q8;
    logic        cin8, iv8, cout8, cout_q8, ovf_q8, ov8;

    // WIDTH = 64 instance
    logic [63:0] a64, b64, sum64, sum_q64;
    logic        cin64, iv64, cout64, cout_q64, ovf_q64, ov64;

    int total;
    int bad;

    full_adder_r #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
        .cout(cout1), .sum(sum1), .sum_q(sum_q1), .cout_q(cout_q1),
        .ovf_q(ovf_q1), .out_valid(ov1)
    );

    full_adder_r #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
        .cout(cout8), .sum(sum8), .sum_q(sum_q8), .cout_q(cout_q8),
        .ovf_q(ovf_q8), .out_valid(ov8)
    );

    full_adder_r #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .cin(cin64), .in_valid(iv64),
        .cout(cout64), .sum(sum64), .sum_q(sum_q64), .cout_q(cout_q64),
        .ovf_q(ovf_q64), .out_valid(ov64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: w-bit add of a + b + cin.
    // ov is derived from operand and result signs, not from internal carries.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, output logic [63:0] s, output logic co,
                         output logic ov);
        logic [63:0] mask;
        logic [64:0] full;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, cin};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    endtask

    logic [63:0] es;
    logic        ec, eo;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a1 = '0; b1 = '0; cin1 = 0; iv1 = 0;
        a8 = '0; b8 = '0; cin8 = 0; iv8 = 0;
        a64 = '0; b64 = '0; cin64 = 0; iv64 = 0;

        // Reset state
        #2;
        chk("rst_sum_q8",  sum_q8,  0);
        chk("rst_cout_q8", cout_q8, 0);
        chk("rst_ovf_q8",  ovf_q8,  0);
        chk("rst_valid8",  ov8,     0);
        chk("rst_valid1",  ov1,     0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table, combinational path only
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0];
            #20;
            model(1, {63'd0, a1}, {63'd0, b1}, cin1, es, ec, eo);
            chk($sformatf("tt%0d", i), {cout1, sum1}, {ec, es[0]});
        end

        // WIDTH=1 capture, then hold with in_valid low
        @(negedge clk);
        a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
        @(posedge clk); #1;
        chk("w1_sum_q",  sum_q1,  1);
        chk("w1_cout_q", cout_q1, 1);
        chk("w1_ovf_q",  ovf_q1,  0);
        chk("w1_valid",  ov1,     1);
        @(negedge clk);
        iv1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        @(posedge clk); #1;
        chk("w1_hold_valid", ov1,     0);
        chk("w1_hold_sum",   sum_q1,  1);
        chk("w1_hold_cout",  cout_q1, 1);

        // WIDTH=8 unsigned wrap, then signed overflow
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 0; iv8 = 1;
        #1;
        chk("w8_ff_sum",  sum8,  8'h00);
        chk("w8_ff_cout", cout8, 1);
        @(posedge clk); #1;
        chk("w8_ff_ovf_q", ovf_q8, 0);
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 0;
        #1;
        chk("w8_7f_sum",  sum8,  8'h80);
        chk("w8_7f_cout", cout8, 0);
        @(posedge clk); #1;
        chk("w8_7f_ovf_q", ovf_q8, 1);

        // Async reset between clock edges
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1;
        @(posedge clk); #1;
        chk("ar_cap_sum",   sum_q8,  8'h00);
        chk("ar_cap_cout",  cout_q8, 1);
        chk("ar_cap_valid", ov8,     1);
        iv8 = 0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sum_q",   sum_q8,  0);
        chk("ar_cout_q",  cout_q8, 0);
        chk("ar_ovf_q",   ovf_q8,  0);
        chk("ar_valid",   ov8,     0);
        chk("ar_w1_sum_q", sum_q1, 0);
        chk("ar_comb_sum",  sum8,  8'h00);
        chk("ar_comb_cout", cout8, 1);
        #1;
        rst_n = 1'b1;

        // WIDTH=8 back-to-back random vectors
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1;
            model(8, {56'd0, a8}, {56'd0, b8}, cin8, es, ec, eo);
            #1;
            chk($sformatf("r8_comb%0d", n), {cout8, sum8}, {ec, es[7:0]});
            @(posedge clk); #1;
            chk($sformatf("r8_q%0d", n), {ov8, ovf_q8, cout_q8, sum_q8}, {1'b1, eo, ec, es[7:0]});
        end
        @(negedge clk);
        iv8 = 0;

        // WIDTH=64 boundary, then random
        a64 = {64{1'b1}}; b64 = {64{1'b1}}; cin64 = 1; iv64 = 1;
        #1;
        chk("w64_sum",  sum64,  {64{1'b1}});
        chk("w64_cout", cout64, 1);
        @(posedge clk); #1;
        chk("w64_q", {ovf_q64, cout_q64, sum_q64}, {1'b0, 1'b1, {64{1'b1}}});
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; cin64 = 1'($urandom);
            model(64, a64, b64, cin64, es, ec, eo);
            @(posedge clk); #1;
            chk($sformatf("r64_%0d", n), {ov64, ovf_q64, cout_q64, sum_q64}, {1'b1, eo, ec, es});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_adder_r.md
Name: full_adder_r

Overview:
- Parameterised ripple-carry full adder: a, b and cin in; sum and cout out.
- Produces a combinational result and a registered copy of it, captured with a valid strobe.
- WIDTH=1 is the classic 1-bit full adder cell (a, b, cin -> cout, sum).
- Used as a leaf arithmetic block inside datapaths. Also serves as the reference adder for gate-level exercises.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, unsigned (two's complement for ovf).
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- in_valid  input  1  capture strobe for the output registers.
- cout  output  1  combinational carry out.
- sum  output  WIDTH  combinational sum.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry out.
- ovf_q  output  1  registered signed overflow.
- out_valid  output  1  registered valid; high when sum_q, cout_q and ovf_q hold a new result.

Behaviour:
- Combinational path, zero latency:
  - {cout, sum} = a + b + cin, computed to WIDTH+1 bits with no truncation.
  - Bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i; c_0 = cin; cout = c_WIDTH.
- Signed overflow: ovf = c_WIDTH ^ c_{WIDTH-1}. For WIDTH=1, ovf = cout ^ cin.
- Registered path, 1-cycle latency:
  - On a rising clk edge with in_valid=1: sum_q<=sum, cout_q<=cout, ovf_q<=ovf, out_valid<=1.
  - On a rising clk edge with in_valid=0: sum_q, cout_q and ovf_q hold their values; out_valid<=0.
- Reset:
  - rst_n=0 asynchronously forces sum_q=0, cout_q=0, ovf_q=0, out_valid=0, independent of clk.
  - Registers stay cleared while rst_n is low.
  - The combinational sum and cout are unaffected by reset and track the inputs at all times.
  - Deasserting rst_n mid-operation: the first capture occurs on the first rising edge with rst_n=1 and in_valid=1.
- No backpressure. in_valid may be high every cycle, giving full throughput with one result per cycle.
- Wrap-around: all-ones + all-ones + 1 gives sum=all-ones, cout=1. All-ones + 0 + 1 gives sum=0, cout=1.
- Inputs of X or Z are not supported. Outputs are undefined for such inputs, and no assertion checks them.

Decomposition:
- Shared package full_adder_pkg holds:
  - localparam MAX_WIDTH=64.
  - A function ref_add(a, b, cin) returning {cout, sum}, used by the verification scoreboard.
- One natural sub-module: full_adder_bit (inputs a, b, cin; outputs cout, sum).
  - Pure combinational, instantiated WIDTH times in a generate loop with the carry chained.
  - The top level adds the carry vector, the overflow XOR and the output register stage.

Test Plan:
- WIDTH=1 exhaustive truth table, applying a,b,cin = 000 through 111 in binary order, 20 time units apart. Required cout,sum per row: 00, 01, 01, 10, 01, 10, 10, 11.
- WIDTH=1 with in_valid=1 and inputs 1,1,1 -> after one rising edge sum_q=1, cout_q=1, out_valid=1. Then drop in_valid -> next edge out_valid=0, sum_q and cout_q held at 1.
- WIDTH=8 with a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf_q=1 after the clock edge.
- Async reset: capture a=0xAA, b=0x55, cin=1 (sum=0x00, cout=1), then pulse rst_n low between clock edges. Required: sum_q=0, cout_q=0, out_valid=0 immediately, with no clock edge. Combinational sum and cout still show 0x00 and 1.
- Back-to-back throughput at WIDTH=8: 256 random vectors with in_valid=1 every cycle. Each cycle's registered outputs must equal ref_add of the previous cycle's inputs.
- Boundary at WIDTH=64: all-ones + all-ones + cin=1 -> sum=all-ones, cout=1, ovf=0.
